// File: rtl/pattern_sequencer.sv
// Pattern buffer bank sequencer: walks bufp/fieldp over buffers start_buf..end_buf
// and hands each field byte to the consumer. Define PATSEQ_LOOP_EN for continuous looping.
module pattern_sequencer #(
  parameter int NUM_BUFS    = 8,
  parameter int BUF_PTR_W   = 3,
  parameter int BUFFER_SIZE = 32,
  parameter int FIELD_PTR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [BUF_PTR_W-1:0]   start_buf,
  input  logic [BUF_PTR_W-1:0]   end_buf,
  input  logic [FIELD_PTR_W:0]   pattern_len,
  input  logic                   field_ack,
  input  logic                   load_active,
  input  logic [BUF_PTR_W-1:0]   load_addr,
  output logic [BUF_PTR_W-1:0]   bufp,
  output logic [FIELD_PTR_W-1:0] fieldp,
  output logic                   incbufp,
  output logic                   incfieldp,
  output logic                   field_valid,
  output logic                   busy,
  output logic                   stall,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUFSET   = 3'd1,
    FIELDSET = 3'd2,
    SETTLE   = 3'd3,
    VALID    = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [BUF_PTR_W-1:0]   BUF_ONE   = BUF_PTR_W'(1);
  localparam logic [BUF_PTR_W-1:0]   BUF_LAST  = BUF_PTR_W'(NUM_BUFS - 1);
  localparam logic [FIELD_PTR_W-1:0] FIELD_ONE = FIELD_PTR_W'(1);
  localparam logic [FIELD_PTR_W:0]   LEN_ONE   = (FIELD_PTR_W+1)'(1);
  localparam logic [FIELD_PTR_W:0]   LEN_FULL  = (FIELD_PTR_W+1)'(BUFFER_SIZE);

  state_t                 state_reg, state_next;
  logic [BUF_PTR_W-1:0]   bufp_reg, bufp_next;
  logic [FIELD_PTR_W-1:0] fieldp_reg, fieldp_next;
  logic [BUF_PTR_W-1:0]   target_reg, target_next;
  logic [BUF_PTR_W-1:0]   end_reg, end_next;
  logic [FIELD_PTR_W-1:0] last_reg, last_next;
`ifdef PATSEQ_LOOP_EN
  logic [BUF_PTR_W-1:0]   start_reg, start_next;
`endif
  logic                   incbufp_reg, incbufp_next;
  logic                   incfieldp_reg, incfieldp_next;
  logic                   valid_reg, valid_next;
  logic                   busy_reg, busy_next;
  logic                   stall_reg, stall_next;
  logic                   done_reg, done_next;

  logic                   conflict;
  logic                   last_byte;
  logic [FIELD_PTR_W:0]   len_eff;
  logic [BUF_PTR_W-1:0]   bufp_succ;

  always_comb begin
    state_next     = state_reg;
    bufp_next      = bufp_reg;
    fieldp_next    = fieldp_reg;
    target_next    = target_reg;
    end_next       = end_reg;
    last_next      = last_reg;
`ifdef PATSEQ_LOOP_EN
    start_next     = start_reg;
`endif
    incbufp_next   = 1'b0;
    incfieldp_next = 1'b0;
    stall_next     = 1'b0;
    done_next      = 1'b0;

    conflict  = load_active && (load_addr == target_reg);
    last_byte = (fieldp_reg >= last_reg);
    len_eff   = (pattern_len == '0) ? LEN_FULL : pattern_len;
    bufp_succ = (bufp_reg == BUF_LAST) ? '0 : bufp_reg + BUF_ONE;

    // stop outranks everything, including a start in the same cycle
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            target_next = start_buf;
            end_next    = end_buf;
            last_next   = FIELD_PTR_W'(len_eff - LEN_ONE);
`ifdef PATSEQ_LOOP_EN
            start_next  = start_buf;
`endif
            state_next  = BUFSET;
          end
        end

        BUFSET: begin
          // never point at a buffer the serial loader is still writing
          if (conflict) begin
            stall_next = 1'b1;
          end else begin
            bufp_next    = target_reg;
            incbufp_next = 1'b1;
            state_next   = FIELDSET;
          end
        end

        FIELDSET: begin
          fieldp_next    = '0;
          incfieldp_next = 1'b1;
          state_next     = SETTLE;
        end

        SETTLE: begin
          state_next = VALID;
        end

        VALID: begin
          if (field_ack) begin
            if (!last_byte) begin
              fieldp_next    = fieldp_reg + FIELD_ONE;
              incfieldp_next = 1'b1;
              state_next     = SETTLE;
            end else if (bufp_reg != end_reg) begin
              target_next = bufp_succ;
              state_next  = BUFSET;
            end else begin
`ifdef PATSEQ_LOOP_EN
              target_next = start_reg;
              done_next   = 1'b1;
              state_next  = BUFSET;
`else
              done_next   = 1'b1;
              state_next  = DONE;
`endif
            end
          end
        end

        DONE: begin
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    valid_next = (state_next == VALID);
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bufp_reg      <= '0;
      fieldp_reg    <= '0;
      target_reg    <= '0;
      end_reg       <= '0;
      last_reg      <= '0;
`ifdef PATSEQ_LOOP_EN
      start_reg     <= '0;
`endif
      incbufp_reg   <= 1'b0;
      incfieldp_reg <= 1'b0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      stall_reg     <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bufp_reg      <= bufp_next;
      fieldp_reg    <= fieldp_next;
      target_reg    <= target_next;
      end_reg       <= end_next;
      last_reg      <= last_next;
`ifdef PATSEQ_LOOP_EN
      start_reg     <= start_next;
`endif
      incbufp_reg   <= incbufp_next;
      incfieldp_reg <= incfieldp_next;
      valid_reg     <= valid_next;
      busy_reg      <= busy_next;
      stall_reg     <= stall_next;
      done_reg      <= done_next;
    end
  end

  assign bufp        = bufp_reg;
  assign fieldp      = fieldp_reg;
  assign incbufp     = incbufp_reg;
  assign incfieldp   = incfieldp_reg;
  assign field_valid = valid_reg;
  assign busy        = busy_reg;
  assign stall       = stall_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: expected (bufp,fieldp) pairs are queued
// when a run is launched and checked as the consumer takes each valid byte.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, field_ack, load_active;
  logic [2:0] start_buf, end_buf, load_addr;
  logic [5:0] pattern_len;
  logic [2:0] bufp;
  logic [4:0] fieldp;
  logic       incbufp, incfieldp, field_valid, busy, stall, done;

  typedef struct packed {
    logic [2:0] b;
    logic [4:0] f;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  logic prev_incbufp = 1'b0;

  always #5 clk = ~clk;

  pattern_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .start_buf(start_buf), .end_buf(end_buf), .pattern_len(pattern_len),
    .field_ack(field_ack), .load_active(load_active), .load_addr(load_addr),
    .bufp(bufp), .fieldp(fieldp), .incbufp(incbufp), .incfieldp(incfieldp),
    .field_valid(field_valid), .busy(busy), .stall(stall), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle, then watch the per-cycle strobe rules
  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (incbufp || incfieldp) chk("inc_exclusive", {31'd0, incbufp & incfieldp}, 32'd0);
    if (prev_incbufp) begin
      chk("fieldset_strobe_after_bufp", {31'd0, incfieldp}, 32'd1);
      chk("fieldp_zero_after_bufp", {27'd0, fieldp}, 32'd0);
    end
    prev_incbufp = incbufp;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!field_valid && n < 40) begin
      tick();
      n++;
    end
    chk("valid_wait", {31'd0, field_valid}, 32'd1);
  endtask

  task automatic launch(input logic [2:0] sb_i, input logic [2:0] eb_i, input logic [5:0] len_i);
    start_buf   = sb_i;
    end_buf     = eb_i;
    pattern_len = len_i;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic push_run(input logic [2:0] sb_i, input logic [2:0] eb_i, input int len_i);
    logic [2:0] b = sb_i;
    forever begin
      for (int i = 0; i < len_i; i++) sb.push_back({b, 5'(i)});
      if (b == eb_i) break;
      b = b + 3'd1;
    end
  endtask

  task automatic consume(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      wait_valid();
      e = sb.pop_front();
      chk("item_bufp", {29'd0, bufp}, {29'd0, e.b});
      chk("item_fieldp", {27'd0, fieldp}, {27'd0, e.f});
      field_ack = 1'b1;
      tick();
      field_ack = 1'b0;
      chk("valid_drop_on_ack", {31'd0, field_valid}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; field_ack = 1'b0; load_active = 1'b0;
    start_buf = '0; end_buf = '0; load_addr = '0; pattern_len = '0;
    tick(); tick();
    chk("rst_bufp", {29'd0, bufp}, 32'd0);
    chk("rst_fieldp", {27'd0, fieldp}, 32'd0);
    chk("rst_flags", {26'd0, incbufp, incfieldp, field_valid, busy, stall, done}, 32'd0);
    reset = 1'b0;
    tick();

`ifdef PATSEQ_LOOP_EN
    push_run(3'd1, 3'd2, 2);
    push_run(3'd1, 3'd2, 2);
    launch(3'd1, 3'd2, 6'd2);
    consume(8);
    chk("loop_done_pulses", done_cnt, 32'd2);
    chk("loop_still_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_stop_idle", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk("loop_no_extra_done", done_cnt, 32'd2);
`else
    // single buffer, three bytes, with latency checks
    push_run(3'd2, 3'd2, 3);
    launch(3'd2, 3'd2, 6'd3);
    chk("t1_busy_k", {31'd0, busy}, 32'd1);
    chk("t1_bufp_k", {29'd0, bufp}, 32'd0);
    tick();
    chk("t1_bufp_k1", {29'd0, bufp}, 32'd2);
    chk("t1_incbufp_k1", {31'd0, incbufp}, 32'd1);
    tick();
    chk("t1_incfieldp_k2", {31'd0, incfieldp}, 32'd1);
    chk("t1_valid_k2", {31'd0, field_valid}, 32'd0);
    tick();
    chk("t1_valid_k3", {31'd0, field_valid}, 32'd1);
    consume(3);
    tick();
    chk("t1_done_once", done_cnt, 32'd1);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // wrapping buffer range 6..1
    push_run(3'd6, 3'd1, 1);
    launch(3'd6, 3'd1, 6'd1);
    consume(4);
    tick();
    chk("t2_done", done_cnt, 32'd2);
    chk("t2_last_bufp", {29'd0, bufp}, 32'd1);

    // loader conflict stalls the buffer select
    load_active = 1'b1;
    load_addr   = 3'd3;
    launch(3'd3, 3'd3, 6'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall", {31'd0, stall}, 32'd1);
      chk("t3_bufp_hold", {29'd0, bufp}, 32'd1);
    end
    load_active = 1'b0;
    tick();
    chk("t3_bufp_after", {29'd0, bufp}, 32'd3);
    chk("t3_stall_clear", {31'd0, stall}, 32'd0);
    sb.push_back({3'd3, 5'd0});
    consume(1);
    tick();
    chk("t3_done", done_cnt, 32'd3);

    // stop while presenting byte 4
    for (int i = 0; i < 4; i++) sb.push_back({3'd5, 5'(i)});
    launch(3'd5, 3'd5, 6'd8);
    consume(4);
    wait_valid();
    chk("t4_fieldp_pre", {27'd0, fieldp}, 32'd4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_valid_off", {31'd0, field_valid}, 32'd0);
    chk("t4_fieldp_hold", {27'd0, fieldp}, 32'd4);
    tick(); tick();
    chk("t4_no_done", done_cnt, 32'd3);

    // stop beats a simultaneous start
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_beats_start", {31'd0, busy}, 32'd0);

    // len=0 means a full 32-byte buffer
    push_run(3'd0, 3'd0, 32);
    launch(3'd0, 3'd0, 6'd0);
    consume(32);
    tick();
    chk("t5_done", done_cnt, 32'd4);
    chk("t5_fieldp_last", {27'd0, fieldp}, 32'd31);

    // reset in the middle of a run
    d0 = done_cnt;
    launch(3'd4, 3'd4, 6'd2);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_bufp", {29'd0, bufp}, 32'd0);
    chk("midrst_fieldp", {27'd0, fieldp}, 32'd0);
    chk("midrst_valid", {31'd0, field_valid}, 32'd0);
    chk("midrst_no_done", done_cnt, d0);
`endif

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
